// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor write side.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_pkg;

    localparam int GHR_W     = 8;
    localparam int PHT_IDX_W = 8;

    // 2-bit saturating counter states
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    // One predicted branch waiting for resolution
    typedef struct packed {
        logic [PHT_IDX_W-1:0] index;
        bp_ctr_t              counter;
        logic                 pred;
    } bp_entry_t;

    // Move one step toward the resolved direction, saturating at both ends.
    function automatic bp_ctr_t sat_update(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != ST) res = bp_ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != SNT) res = bp_ctr_t'(ctr - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight branch queue: DEPTH entries of bp_entry_t, oldest at head.
// Latency: push visible at head next cycle; head is a combinational read.
// Backpressure: full/empty flags; push when full and pop when empty are ignored.
// Ports: push/push_dat enqueue, pop dequeues head, clear empties the queue.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  bp_entry_t push_dat,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output bp_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the slots match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    bp_entry_t   mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/pht_updater.sv
// gshare PHT write-side controller: read-index hash, in-flight queue, GHRs, PHT write port.
// Latency: rindex/pred_taken/fetch_stall/mispredict combinational; PHT write one cycle after resolve.
// Backpressure: fetch_stall while the in-flight queue is full (pre-pop count).
// Ports: fetch_* from IF, resolve_* and flush from EX, pht_* drive the PHT write port.
module pht_updater
    import bp_pkg::*;
#(
    parameter int GHR_W = bp_pkg::GHR_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_br_valid,
    input  logic [31:0]      fetch_pc,
    input  logic [1:0]       fetch_counter,
    output logic [GHR_W-1:0] rindex,
    output logic             pred_taken,
    output logic             fetch_stall,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    output logic             mispredict,
    input  logic             flush,
    output logic             pht_write,
    output logic [GHR_W-1:0] pht_windex,
    output logic [1:0]       pht_datain
);

    logic [GHR_W-1:0] spec_ghr;
    logic [GHR_W-1:0] commit_ghr;
    logic [GHR_W-1:0] commit_ghr_nxt;

    logic      q_full;
    logic      q_empty;
    logic      q_push;
    logic      q_pop;
    logic      q_clear;
    bp_entry_t q_head;
    bp_entry_t q_push_dat;

    // Only the word-aligned index bits of the PC feed the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[31:GHR_W+2], fetch_pc[1:0]};

    assign rindex      = fetch_pc[GHR_W+1:2] ^ spec_ghr;
    assign pred_taken  = fetch_counter[1];
    assign fetch_stall = q_full;

    assign q_pop      = resolve_valid && !q_empty;
    assign mispredict = q_pop && (resolve_taken != q_head.pred);
    assign q_clear    = mispredict || flush;
    // A branch fetched alongside a redirect is on the wrong path.
    assign q_push     = fetch_br_valid && !q_full && !flush && !mispredict;

    assign q_push_dat = '{index: rindex, counter: bp_ctr_t'(fetch_counter), pred: pred_taken};

    // Committed history including a resolve in this same cycle; recovery
    // (mispredict or flush) restores speculative history from this value.
    assign commit_ghr_nxt = q_pop ? {commit_ghr[GHR_W-2:0], resolve_taken} : commit_ghr;

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .clear    (q_clear),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr   <= '0;
            commit_ghr <= '0;
        end else begin
            commit_ghr <= commit_ghr_nxt;
            if (q_clear) begin
                spec_ghr <= commit_ghr_nxt;
            end else if (q_push) begin
                spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken};
            end
        end
    end

    // Write port: the counter captured at fetch is updated, not re-read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pht_write  <= 1'b0;
            pht_windex <= '0;
            pht_datain <= '0;
        end else begin
            pht_write <= q_pop;
            if (q_pop) begin
                pht_windex <= q_head.index;
                pht_datain <= sat_update(q_head.counter, resolve_taken);
            end
        end
    end

endmodule

// File: tb/tb_pht_updater.sv
// Self-checking bench for pht_updater: reference queue/GHR model plus a write scoreboard.
// Latency: expected PHT writes are queued at the resolve edge and compared one cycle later.
// Backpressure: the model tracks queue occupancy and checks fetch_stall every cycle.
module tb_pht_updater;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_br_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_counter;
    logic [7:0]  rindex;
    logic        pred_taken;
    logic        fetch_stall;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic        flush;
    logic        pht_write;
    logic [7:0]  pht_windex;
    logic [1:0]  pht_datain;

    always #5 clk = ~clk;

    pht_updater #(.GHR_W(8), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_br_valid (fetch_br_valid),
        .fetch_pc       (fetch_pc),
        .fetch_counter  (fetch_counter),
        .rindex         (rindex),
        .pred_taken     (pred_taken),
        .fetch_stall    (fetch_stall),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .mispredict     (mispredict),
        .flush          (flush),
        .pht_write      (pht_write),
        .pht_windex     (pht_windex),
        .pht_datain     (pht_datain)
    );

    typedef struct {
        logic [7:0] idx;
        logic [1:0] ctr;
        logic       pred;
    } m_entry_t;

    m_entry_t    mq[$];
    logic [9:0]  wr_q[$];
    logic [7:0]  m_spec;
    logic [7:0]  m_commit;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? 2'b11 : c + 2'd1;
        else   return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction

    task automatic drive(input logic br, input logic [31:0] pc, input logic [1:0] ctr,
                         input logic rv, input logic rt, input logic fl, input logic rs);
        fetch_br_valid = br;
        fetch_pc       = pc;
        fetch_counter  = ctr;
        resolve_valid  = rv;
        resolve_taken  = rt;
        flush          = fl;
        rst            = rs;
    endtask

    // Check combinational outputs against the model, clock once, advance the
    // model, then compare the write port against the scoreboard.
    task automatic cycle();
        logic       m_full, m_pop, m_mis, m_push;
        logic [7:0] m_idx;
        m_entry_t   e;
        #1;
        m_full = (mq.size() == DEPTH);
        m_pop  = resolve_valid && (mq.size() > 0);
        m_mis  = m_pop && (resolve_taken != mq[0].pred);
        m_push = fetch_br_valid && !m_full && !flush && !m_mis;
        m_idx  = fetch_pc[9:2] ^ m_spec;
        check("rindex", rindex, m_idx);
        check("pred_taken", pred_taken, fetch_counter[1]);
        check("fetch_stall", fetch_stall, m_full);
        check("mispredict", mispredict, m_mis);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            wr_q.delete();
            m_spec   = 8'h00;
            m_commit = 8'h00;
        end else begin
            if (m_pop) begin
                e = mq.pop_front();
                wr_q.push_back({e.idx, m_sat(e.ctr, resolve_taken)});
                m_commit = {m_commit[6:0], resolve_taken};
            end
            if (m_mis || flush) begin
                mq.delete();
                m_spec = m_commit;
            end else if (m_push) begin
                e.idx  = m_idx;
                e.ctr  = fetch_counter;
                e.pred = fetch_counter[1];
                mq.push_back(e);
                m_spec = {m_spec[6:0], fetch_counter[1]};
            end
        end
        #1;
        if (wr_q.size() > 0) begin
            logic [9:0] w;
            w = wr_q.pop_front();
            check("pht_write", pht_write, 1'b1);
            check("pht_windex", pht_windex, w[9:2]);
            check("pht_datain", pht_datain, w[1:0]);
        end else begin
            check("pht_write_idle", pht_write, 1'b0);
        end
    endtask

    initial begin
        m_spec   = 8'h00;
        m_commit = 8'h00;

        // Reset
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_write", pht_write, 1'b0);
        check("rst_windex", pht_windex, 8'h00);
        check("rst_datain", pht_datain, 2'b00);
        check("rst_stall", fetch_stall, 1'b0);
        check("rst_misp", mispredict, 1'b0);
        check("rst_ghr", rindex, 8'h00);

        // Single branch: mispredicted weakly-NT resolved taken
        drive(1, 32'h40, 2'b01, 0, 0, 0, 0);
        #1;
        check("t1_rindex", rindex, 8'h10);
        check("t1_pred", pred_taken, 1'b0);
        cycle();
        drive(0, 0, 0, 1, 1, 0, 0);
        #1;
        check("t1_misp", mispredict, 1'b1);
        cycle();
        check("t1_wr_idx", pht_windex, 8'h10);
        check("t1_wr_dat", pht_datain, 2'b10);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("t1_spec_ghr", rindex, 8'h01);
        cycle();

        // Saturation at both ends
        drive(1, 32'h80, 2'b11, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();
        check("sat_hi", pht_datain, 2'b11);
        drive(1, 32'h84, 2'b00, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0, 0, 0);
        cycle();
        check("sat_lo", pht_datain, 2'b00);

        // Fill the queue, then resolve with a branch waiting in IF
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h100 + 32'(i * 4), 2'b10, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 32'h200, 2'b10, 0, 0, 0, 0);
        #1;
        check("fill_stall", fetch_stall, 1'b1);
        cycle();
        drive(1, 32'h200, 2'b10, 1, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fill_stall_drop", fetch_stall, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();

        // Mispredict with three taken predictions in flight
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 2'b11, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 32'h400, 2'b11, 1, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("misp_spec_ghr", rindex, 8'h00);
        check("misp_stall", fetch_stall, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0);
            cycle();
        end

        // Flush together with a correctly predicted resolve
        drive(1, 32'h500, 2'b01, 0, 0, 0, 0);
        cycle();
        drive(1, 32'h504, 2'b01, 0, 0, 0, 0);
        cycle();
        drive(1, 32'h508, 2'b11, 1, 0, 1, 0);
        cycle();
        check("flush_write", pht_write, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("flush_spec_ghr", rindex, 8'h00);
        drive(0, 0, 0, 1, 1, 0, 0);
        cycle();

        // Reset with two branches in flight and a resolve pending
        drive(1, 32'h600, 2'b10, 0, 0, 0, 0);
        cycle();
        drive(1, 32'h604, 2'b10, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 1, 0, 1);
        cycle();
        check("mrst_write", pht_write, 1'b0);
        drive(0, 0, 0, 1, 1, 0, 0);
        #1;
        check("mrst_ghr", rindex, 8'h00);
        check("mrst_stall", fetch_stall, 1'b0);
        check("mrst_misp", mispredict, 1'b0);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
